// File: rtl/rvc_compress_packer.sv
// rvc_compress_packer: replaces RV32I instructions from the loader stream with
// their 16-bit RVC forms where possible and packs the resulting halfword stream
// little-endian into 32-bit words for the instruction memory write port.
// Optional feature: define RVC_CA_EN to also compress SUB/XOR/OR/AND (CA format).
module rvc_compress_packer #(
  parameter logic [15:0] NOP_PAD = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_ins,
  input  logic        flush,
  output logic        flush_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        hold_valid
);

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;

  assign opcode = in_ins[6:0];
  assign rd     = in_ins[11:7];
  assign funct3 = in_ins[14:12];
  assign rs1    = in_ins[19:15];
  assign rs2    = in_ins[24:20];
  assign funct7 = in_ins[31:25];
  assign imm_i  = in_ins[31:20];
  assign imm_s  = {in_ins[31:25], in_ins[11:7]};

  // Immediate range qualifiers; a 12-bit value fits in 6 signed bits when
  // bits [11:5] are all equal to the sign.
  logic imm_i_small;
  logic imm_i_nz;
  logic lw_imm_ok;
  logic sw_imm_ok;
  logic rd_p;
  logic rs1_p;
  logic rs2_p;

  assign imm_i_small = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);
  assign imm_i_nz    = (imm_i != 12'h000);
  assign lw_imm_ok   = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00);
  assign sw_imm_ok   = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00);
  assign rd_p        = (rd[4:3]  == 2'b01);
  assign rs1_p       = (rs1[4:3] == 2'b01);
  assign rs2_p       = (rs2[4:3] == 2'b01);

  logic        c_ok;
  logic [15:0] c_form;

  // Compression: first matching rule wins; anything else passes through
  always_comb begin
    c_ok   = 1'b0;
    c_form = 16'h0000;
    if (in_ins[1:0] == 2'b11) begin
      if (opcode == 7'b0010011 && funct3 == 3'b000 && rd == rs1 && rd != 5'd0
          && imm_i_small && imm_i_nz) begin
        c_ok   = 1'b1;
        c_form = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
      end else if (opcode == 7'b0010011 && funct3 == 3'b000 && rs1 == 5'd0
                   && rd != 5'd0 && imm_i_small) begin
        c_ok   = 1'b1;
        c_form = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
      end else if (opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0000000
                   && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
        c_ok   = 1'b1;
        c_form = {4'b1001, rd, rs2, 2'b10};
      end else if (opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0000000
                   && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
        c_ok   = 1'b1;
        c_form = {4'b1000, rd, rs2, 2'b10};
      end else if (opcode == 7'b1100111 && funct3 == 3'b000 && rd == 5'd0
                   && rs1 != 5'd0 && !imm_i_nz) begin
        c_ok   = 1'b1;
        c_form = {4'b1000, rs1, 5'b00000, 2'b10};
      end else if (opcode == 7'b1100111 && funct3 == 3'b000 && rd == 5'd1
                   && rs1 != 5'd0 && !imm_i_nz) begin
        c_ok   = 1'b1;
        c_form = {4'b1001, rs1, 5'b00000, 2'b10};
      end else if (opcode == 7'b0000011 && funct3 == 3'b010 && rd_p && rs1_p
                   && lw_imm_ok) begin
        c_ok   = 1'b1;
        c_form = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
      end else if (opcode == 7'b0100011 && funct3 == 3'b010 && rs2_p && rs1_p
                   && sw_imm_ok) begin
        c_ok   = 1'b1;
        c_form = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
      end
`ifdef RVC_CA_EN
      else if (opcode == 7'b0110011 && rd == rs1 && rd_p && rs2_p) begin
        if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          c_ok   = 1'b1;
          c_form = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
        end else if (funct7 == 7'b0000000 && funct3 == 3'b100) begin
          c_ok   = 1'b1;
          c_form = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
        end else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin
          c_ok   = 1'b1;
          c_form = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
        end else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin
          c_ok   = 1'b1;
          c_form = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
        end
      end
`endif
    end
  end

  // Handshake: the single output register is free when empty or being drained
  logic slot_free;
  logic accept;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !flush;
  assign accept    = in_valid && in_ready;

  logic [15:0] hold_data;

  // Packing state: hold register for an odd halfword plus the output word slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_word   <= 32'h0000_0000;
      hold_valid <= 1'b0;
      hold_data  <= 16'h0000;
      flush_ack  <= 1'b0;
    end else begin
      flush_ack <= 1'b0;
      if (slot_free) begin
        if (flush) begin
          flush_ack <= 1'b1;
          if (hold_valid) begin
            out_word   <= {NOP_PAD, hold_data};
            out_valid  <= 1'b1;
            hold_valid <= 1'b0;
          end else begin
            out_valid <= 1'b0;
          end
        end else if (accept) begin
          case ({hold_valid, c_ok})
            2'b01: begin
              hold_data  <= c_form;
              hold_valid <= 1'b1;
              out_valid  <= 1'b0;
            end
            2'b00: begin
              out_word  <= in_ins;
              out_valid <= 1'b1;
            end
            2'b11: begin
              out_word   <= {c_form, hold_data};
              out_valid  <= 1'b1;
              hold_valid <= 1'b0;
            end
            default: begin
              out_word  <= {in_ins[15:0], hold_data};
              out_valid <= 1'b1;
              hold_data <= in_ins[31:16];
            end
          endcase
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rvc_compress_packer.sv
// Directed self-checking bench for rvc_compress_packer.
// Honours RVC_CA_EN the same way as the design.
module tb_rvc_compress_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ins;
  logic        flush;
  logic        flush_ack;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        hold_valid;

  int checkCount = 0;
  int passCount  = 0;

  rvc_compress_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ins     (in_ins),
    .flush      (flush),
    .flush_ack  (flush_ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .hold_valid (hold_valid)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  // Present one instruction and hold it until the design takes it
  task automatic applyStimulus(input logic [31:0] ins);
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_ins   = ins;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flushCycle();
    flush = 1'b1;
    #1;
    checkOutput("flush_blocks_input", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  // Feed two instructions and check the single packed word they form
  task automatic pairCheck(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] word);
    applyStimulus(a);
    checkOutput({tag, "_held"}, 32'(hold_valid), 32'd1);
    applyStimulus(b);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_word"}, out_word, word);
    checkOutput({tag, "_hold_clear"}, 32'(hold_valid), 32'd0);
    idleCycle();
  endtask

  // Feed one non-compressible instruction with an empty hold register
  task automatic passCheck(input string tag, input logic [31:0] ins);
    applyStimulus(ins);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_word"}, out_word, ins);
    checkOutput({tag, "_hold"}, 32'(hold_valid), 32'd0);
    idleCycle();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ins    = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_word", out_word, 32'h0);
    checkOutput("rst_hold_valid", 32'(hold_valid), 32'd0);
    checkOutput("rst_flush_ack", 32'(flush_ack), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle();

    // Two C.ADDI halves pack into one word
    pairCheck("addi_pair", 32'h00550513, 32'h00550513, 32'h05150515);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);

    // Plain ADD passes through
    passCheck("add_pass", 32'h007302B3);

    // C.LW held, ADD splits across the hold, flush pads with C.NOP
    applyStimulus(32'h00842483);
    checkOutput("lw_held", 32'(hold_valid), 32'd1);
    checkOutput("lw_no_out", 32'(out_valid), 32'd0);
    applyStimulus(32'h007302B3);
    checkOutput("lw_add_word", out_word, 32'h02B34404);
    checkOutput("lw_add_hold", 32'(hold_valid), 32'd1);
    flushCycle();
    checkOutput("flush_valid", 32'(out_valid), 32'd1);
    checkOutput("flush_word", out_word, 32'h00010073);
    checkOutput("flush_ack", 32'(flush_ack), 32'd1);
    checkOutput("flush_hold", 32'(hold_valid), 32'd0);
    idleCycle();
    checkOutput("flush_ack_pulse", 32'(flush_ack), 32'd0);

    // Remaining compressed forms
    pairCheck("li_mv", 32'hFFF00093, 32'h004001B3, 32'h819250FD);
    pairCheck("jr_jalr", 32'h00008067, 32'h000280E7, 32'h92828082);
    pairCheck("sw_add", 32'h0697AE23, 32'h006282B3, 32'h929ADFE4);
    passCheck("addi_imm32", 32'h02050513);
    passCheck("addi_imm0", 32'h00050513);

    // Backpressure: output holds, input stalls, nothing is lost on release
    out_ready = 1'b0;
    applyStimulus(32'h007302B3);
    in_valid = 1'b1;
    in_ins   = 32'h00550513;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_word", out_word, 32'h007302B3);
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      idleCycle();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_taken_hold", 32'(hold_valid), 32'd1);
    checkOutput("bp_taken_out", 32'(out_valid), 32'd0);
    applyStimulus(32'h00550513);
    checkOutput("bp_pair_word", out_word, 32'h05150515);
    idleCycle();

    // Asynchronous reset mid-cycle drops the held halfword
    applyStimulus(32'h00550513);
    checkOutput("pre_reset_hold", 32'(hold_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_hold", 32'(hold_valid), 32'd0);
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_ack", 32'(flush_ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle();
    flushCycle();
    checkOutput("empty_flush_ack", 32'(flush_ack), 32'd1);
    checkOutput("empty_flush_out", 32'(out_valid), 32'd0);
    idleCycle();

    // SUB x8,x8,x9: CA form only when the option is built in
`ifdef RVC_CA_EN
    applyStimulus(32'h40940433);
    checkOutput("sub_held", 32'(hold_valid), 32'd1);
    flushCycle();
    checkOutput("sub_flush_word", out_word, 32'h00018C05);
    checkOutput("sub_flush_ack", 32'(flush_ack), 32'd1);
`else
    passCheck("sub_pass", 32'h40940433);
    flushCycle();
    checkOutput("sub_flush_ack", 32'(flush_ack), 32'd1);
    checkOutput("sub_flush_out", 32'(out_valid), 32'd0);
`endif
    idleCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
